// File: rtl/da_sequencer_if.sv
// Stream, config and DA-core signal bundle for da_sequencer.
// "master" is the sequencer's view; "slave" is the view of the surrounding system and core.
interface da_sequencer_if #(
    parameter int SAMPLE_W = 16
);
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_data;

    logic                y_valid;
    logic                y_ready;
    logic [37:0]         y_data;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [10:0]         cfg_addr;
    logic [18:0]         cfg_data;

    logic [7:0]          da_A0;
    logic [7:0]          da_A1;
    logic [7:0]          da_A2;
    logic [7:0]          da_A3;
    logic [7:0]          da_A4;
    logic [7:0]          da_A5;
    logic [7:0]          da_A6;
    logic [7:0]          da_A7;
    logic                da_start;
    logic                da_reset;
    logic                da_done;
    logic [37:0]         da_acc;
    logic                da_cload;
    logic [10:0]         da_caddr;
    logic [18:0]         da_cin;

    logic                busy;

    modport master (
        input  s_valid, s_data, y_ready, cfg_valid, cfg_addr, cfg_data, da_done, da_acc,
        output s_ready, y_valid, y_data, cfg_ready,
        output da_A0, da_A1, da_A2, da_A3, da_A4, da_A5, da_A6, da_A7,
        output da_start, da_reset, da_cload, da_caddr, da_cin, busy
    );

    modport slave (
        output s_valid, s_data, y_ready, cfg_valid, cfg_addr, cfg_data, da_done, da_acc,
        input  s_ready, y_valid, y_data, cfg_ready,
        input  da_A0, da_A1, da_A2, da_A3, da_A4, da_A5, da_A6, da_A7,
        input  da_start, da_reset, da_cload, da_caddr, da_cin, busy
    );
endinterface

// File: rtl/da_sequencer.sv
// Bit-serial front end for the 64-tap distributed-arithmetic FIR core: delay line,
// per-plane address sequencing and coefficient-ROM write arbitration. DA_SEQ_FLUSH_EN adds a flush port.
module da_sequencer #(
    parameter int SAMPLE_W = 16,
    parameter int TAPS     = 64
) (
    input  logic clk,
    input  logic resetn,
`ifdef DA_SEQ_FLUSH_EN
    input  logic flush,
`endif
    da_sequencer_if.master bus
);
    localparam int BW = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

    generate
        if (TAPS != 64) begin : g_bad_taps
            $error("da_sequencer: TAPS must be 64 (8 banks x 8 address bits)");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, CFG_WR, CLR, BIT_START, BIT_WAIT, CAPTURE, OUT
    } state_t;

    state_t              state_reg;
    logic [BW-1:0]       bit_reg;
    logic [SAMPLE_W-1:0] x_reg [TAPS];
    logic [7:0][7:0]     addr_reg;
    logic                da_start_reg;
    logic                da_reset_reg;
    logic                da_cload_reg;
    logic                cfg_ready_reg;
    logic [10:0]         da_caddr_reg;
    logic [18:0]         da_cin_reg;
    logic                y_valid_reg;
    logic [37:0]         y_data_reg;

    logic                flush_req;
    logic                accept;
    logic                clear_hist;
    logic [BW-1:0]       plane_sel;
    logic [TAPS-1:0]     plane_bits;

`ifdef DA_SEQ_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign bus.s_ready = (state_reg == IDLE) && !bus.cfg_valid && !flush_req;
    assign accept      = bus.s_ready && bus.s_valid;
    assign clear_hist  = (state_reg == IDLE) && flush_req;
    assign bus.busy    = (state_reg != IDLE);

    // Plane that the next BIT_START will present: MSB after CLR, otherwise one below the current.
    assign plane_sel = (state_reg == CLR) ? BW'(SAMPLE_W - 1) : (bit_reg - BW'(1));

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_plane
            assign plane_bits[gi] = x_reg[gi][plane_sel];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TAPS; i++) x_reg[i] <= '0;
        end else if (clear_hist) begin
            for (int i = 0; i < TAPS; i++) x_reg[i] <= '0;
        end else if (accept) begin
            x_reg[0] <= bus.s_data;
            for (int i = 1; i < TAPS; i++) x_reg[i] <= x_reg[i-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            bit_reg       <= BW'(SAMPLE_W - 1);
            addr_reg      <= '0;
            da_start_reg  <= 1'b0;
            da_reset_reg  <= 1'b0;
            da_cload_reg  <= 1'b0;
            cfg_ready_reg <= 1'b0;
            da_caddr_reg  <= '0;
            da_cin_reg    <= '0;
            y_valid_reg   <= 1'b0;
            y_data_reg    <= '0;
        end else begin
            da_start_reg  <= 1'b0;
            da_reset_reg  <= 1'b0;
            da_cload_reg  <= 1'b0;
            cfg_ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (flush_req) begin
                        state_reg <= IDLE;
                    end else if (bus.cfg_valid) begin
                        state_reg     <= CFG_WR;
                        da_cload_reg  <= 1'b1;
                        cfg_ready_reg <= 1'b1;
                        da_caddr_reg  <= bus.cfg_addr;
                        da_cin_reg    <= bus.cfg_data;
                    end else if (bus.s_valid) begin
                        state_reg    <= CLR;
                        da_reset_reg <= 1'b1;
                    end
                end
                CFG_WR: state_reg <= IDLE;
                CLR: begin
                    state_reg    <= BIT_START;
                    bit_reg      <= BW'(SAMPLE_W - 1);
                    addr_reg     <= plane_bits;
                    da_start_reg <= 1'b1;
                end
                BIT_START: state_reg <= BIT_WAIT;
                BIT_WAIT: begin
                    if (bus.da_done) begin
                        if (bit_reg == '0) begin
                            state_reg <= CAPTURE;
                        end else begin
                            state_reg    <= BIT_START;
                            bit_reg      <= bit_reg - BW'(1);
                            addr_reg     <= plane_bits;
                            da_start_reg <= 1'b1;
                        end
                    end
                end
                // The core writes ACC one cycle after done, so the result is taken here.
                CAPTURE: begin
                    state_reg   <= OUT;
                    y_data_reg  <= bus.da_acc;
                    y_valid_reg <= 1'b1;
                end
                OUT: begin
                    if (bus.y_ready) begin
                        state_reg   <= IDLE;
                        y_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.da_A0     = addr_reg[0];
    assign bus.da_A1     = addr_reg[1];
    assign bus.da_A2     = addr_reg[2];
    assign bus.da_A3     = addr_reg[3];
    assign bus.da_A4     = addr_reg[4];
    assign bus.da_A5     = addr_reg[5];
    assign bus.da_A6     = addr_reg[6];
    assign bus.da_A7     = addr_reg[7];
    assign bus.da_start  = da_start_reg;
    assign bus.da_reset  = da_reset_reg;
    assign bus.da_cload  = da_cload_reg;
    assign bus.cfg_ready = cfg_ready_reg;
    assign bus.da_caddr  = da_caddr_reg;
    assign bus.da_cin    = da_cin_reg;
    assign bus.y_valid   = y_valid_reg;
    assign bus.y_data    = y_data_reg;
endmodule
